// File: rtl/rsa_modmul_if.sv
// Handshake and operand bundle for the rsa_modmul datapath stage.
// The err line exists only when RSA_MODMUL_CHECK_EN is defined.
interface rsa_modmul_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] n;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             finished;
`ifdef RSA_MODMUL_CHECK_EN
    logic             err;

    modport master (output start, a, b, n, input result, busy, finished, err);
    modport slave  (input start, a, b, n, output result, busy, finished, err);
`else
    modport master (output start, a, b, n, input result, busy, finished);
    modport slave  (input start, a, b, n, output result, busy, finished);
`endif
endinterface

// File: rtl/rsa_modmul.sv
// Iterative interleaved modular multiplier: result = (a * b) mod n, one multiplier bit per clock, MSB first.
// Optional operand check (n = 0 or a >= n flagged on err) is enabled by defining RSA_MODMUL_CHECK_EN.
module rsa_modmul #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic          clk,
    input  logic          rst,
    rsa_modmul_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t             state_r, state_s;
    logic [WIDTH-1:0]   a_r, a_s;
    logic [WIDTH-1:0]   b_r, b_s;
    logic [WIDTH-1:0]   n_r, n_s;
    logic [WIDTH-1:0]   acc_r, acc_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic [WIDTH-1:0]   result_r, result_s;
    logic               busy_r, busy_s;
    logic               finished_r, finished_s;
    logic               err_r, err_s;
    logic               op_bad_s;
    logic [WIDTH-1:0]   dbl_s;
    logic [WIDTH-1:0]   step_s;

    // One conditional subtraction on a WIDTH+1 bit value; the result fits WIDTH bits when t < 2n.
    function automatic logic [WIDTH-1:0] cond_sub(input logic [WIDTH:0] t, input logic [WIDTH:0] m);
        if (t >= m) begin
            return WIDTH'(t - m);
        end else begin
            return WIDTH'(t);
        end
    endfunction

    // Operand precondition check at acceptance time.
`ifdef RSA_MODMUL_CHECK_EN
    always_comb begin
        op_bad_s = (bus.n == {WIDTH{1'b0}}) || (bus.a >= bus.n);
    end
`else
    always_comb begin
        op_bad_s = 1'b0;
    end
`endif

    // Single multiplier step: double, reduce, conditionally add a, reduce. b_r is shifted so its MSB is the current bit.
    always_comb begin
        dbl_s = cond_sub({acc_r, 1'b0}, {1'b0, n_r});
        if (b_r[WIDTH-1]) begin
            step_s = cond_sub({1'b0, dbl_s} + {1'b0, a_r}, {1'b0, n_r});
        end else begin
            step_s = dbl_s;
        end
    end

    // Next-state and next-output logic for the IDLE/CALC/DONE controller.
    always_comb begin
        state_s    = state_r;
        a_s        = a_r;
        b_s        = b_r;
        n_s        = n_r;
        acc_s      = acc_r;
        cnt_s      = cnt_r;
        result_s   = result_r;
        busy_s     = busy_r;
        finished_s = 1'b0;
        err_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    a_s    = bus.a;
                    b_s    = bus.b;
                    n_s    = bus.n;
                    acc_s  = {WIDTH{1'b0}};
                    cnt_s  = CNT_W'(WIDTH - 1);
                    busy_s = 1'b1;
                    if (op_bad_s) begin
                        result_s   = {WIDTH{1'b0}};
                        finished_s = 1'b1;
                        err_s      = 1'b1;
                        state_s    = DONE;
                    end else begin
                        state_s = CALC;
                    end
                end else begin
                    busy_s = 1'b0;
                end
            end
            CALC: begin
                acc_s = step_s;
                b_s   = {b_r[WIDTH-2:0], 1'b0};
                if (cnt_r == {CNT_W{1'b0}}) begin
                    result_s   = step_s;
                    finished_s = 1'b1;
                    state_s    = DONE;
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            DONE: begin
                busy_s  = 1'b0;
                state_s = IDLE;
            end
            default: begin
                busy_s  = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // State and datapath registers; every output is taken straight from a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            a_r        <= {WIDTH{1'b0}};
            b_r        <= {WIDTH{1'b0}};
            n_r        <= {WIDTH{1'b0}};
            acc_r      <= {WIDTH{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            result_r   <= {WIDTH{1'b0}};
            busy_r     <= 1'b0;
            finished_r <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            a_r        <= a_s;
            b_r        <= b_s;
            n_r        <= n_s;
            acc_r      <= acc_s;
            cnt_r      <= cnt_s;
            result_r   <= result_s;
            busy_r     <= busy_s;
            finished_r <= finished_s;
            err_r      <= err_s;
        end
    end

    assign bus.result   = result_r;
    assign bus.busy     = busy_r;
    assign bus.finished = finished_r;
`ifdef RSA_MODMUL_CHECK_EN
    assign bus.err      = err_r;
`else
    logic unused_err_s;
    assign unused_err_s = err_r;
`endif

endmodule

// File: doc/rsa_modmul.md
Name: rsa_modmul

Overview:
- Iterative interleaved (shift-and-add) modular multiplier: result = (a * b) mod n.
- Datapath stage sitting directly downstream of the RSA_binary exponentiation controller. The controller's start/finished FSM issues one square or one multiply per round; this block executes it.
- Processes one multiplier bit per clock, MSB first, using a single conditional subtraction per step.

Parameters:
- WIDTH, 8, operand/modulus bit width (>= 2).
- CNT_W, 4, iteration counter width; must satisfy 2**CNT_W >= WIDTH.

Ports:
- clk  input  1  rising-edge clock, sole clock domain.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  multiplicand; precondition a < n.
- b  input  WIDTH  multiplier; any value.
- n  input  WIDTH  modulus; precondition n > 0.
- result  output  WIDTH  product mod n; valid from the finished pulse until the next accepted start.
- busy  output  1  high from the accepting edge until finished falls.
- finished  output  1  one-cycle completion pulse.

Behaviour:
- Reset (async, rst=1): state=IDLE; result=0, busy=0, finished=0; counter=0, accumulator R=0.
- States: IDLE, CALC, DONE. Encoding is free; all outputs are registered.
- IDLE:
  - When start=1 at edge E, latch a, b and n into internal registers, clear R, set counter=WIDTH-1, go to CALC, busy=1.
  - Input changes after edge E have no effect.
- CALC, each edge, with i = counter:
  - T = 2R; if T >= n then T = T - n.
  - If b_reg[i] = 1: T = T + a_reg; if T >= n then T = T - n.
  - R = T.
  - Internal arithmetic is WIDTH+1 bits wide, so no overflow is possible given a < n.
  - When counter = 0: load result = T, set finished=1, go to DONE. Otherwise decrement counter.
- Latency: finished is high during the cycle after edge E+WIDTH. For WIDTH=8, that is 8 clocks after the start capture.
- DONE:
  - Lasts exactly one cycle. finished=1, busy=1.
  - At the next edge: finished=0, busy=0, state returns to IDLE.
  - A start held high through DONE is not accepted until IDLE, so back-to-back operations restart one cycle later.
- start while busy (CALC or DONE): ignored, with no queuing and no effect on the in-flight operation.
- result holds its value through IDLE and is updated only at the final CALC edge.
- Reset asserted mid-operation aborts immediately. No finished pulse is issued; all outputs return to their reset values.
- Precondition violation (a >= n or n = 0) without the check feature: result is undefined, but timing is unchanged and the FSM must never hang.
- Boundary values:
  - b = 0 or a = 0 gives result 0.
  - n = 1 gives result 0.
  - a = n-1 and b = 2**WIDTH-1 must not overflow.

Optional Feature:
- Macro: RSA_MODMUL_CHECK_EN.
- Defined:
  - Adds output err (1 bit, reset 0).
  - At start acceptance, if n = 0 or a >= n, skip CALC and go directly to DONE. finished and err pulse together in the cycle after edge E, result is loaded with 0, and busy is high for that one cycle.
  - err is 0 on all valid operations.
- Undefined: no err port and no operand check. Behaviour follows the precondition-violation rule above.

Test Plan:
- WIDTH=8; a=5, b=7, n=13, pulse start -> finished exactly 8 clocks after capture, result=9, busy high for 9 cycles.
- a=200, b=250, n=251 -> result=51. Then a=250, b=255, n=251 -> result=247. Also a=0, b=77, n=13 -> result=0.
- Hold start high continuously with a=3, b=4, n=7 -> result=5 on each finished pulse; pulses spaced 10 cycles apart, with no start accepted during CALC or DONE.
- Mid-CALC (4 cycles after capture), change a/b/n and pulse start -> ignored; result matches the originally latched operands.
- Assert rst 3 cycles into CALC -> busy, finished and result go to 0 immediately; no finished pulse; next start computes correctly.
- With RSA_MODMUL_CHECK_EN: n=0 or a=20, n=13 -> finished=1 and err=1 one cycle after capture, result=0. Valid operands -> err=0.
